lane_group_serializer: RTL and testbench



---
 rtl/lane_group_serializer.sv | 124 ++++++++++++
 tb/tb_lane_group_serializer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/lane_group_serializer.sv
// lane_group_serializer
//   Buffers one NUM_IN-lane vector per transaction and streams it out as
//   OUT_LANES-wide beats, ascending or descending group order, with a
//   run-time beat count.
//
// Ports
//   clk, reset      clock; asynchronous active-high reset
//   in_valid        input transaction valid
//   in_ready        transaction can be accepted this cycle (comb from out_ready)
//   in_data         NUM_IN lanes, lane i at [i*DATA_W +: DATA_W]
//   in_beats        beats to emit; 0 or >NUM_BEATS means NUM_BEATS
//   in_reverse      1 = highest group first
//   out_valid       output beat valid
//   out_ready       downstream accepts beat
//   out_data        current group, lowest lane in LSBs; 0 when idle
//   out_beat_idx    group index presented
//   out_last        final beat of the transaction
//   busy            transaction in progress
module lane_group_serializer #(
    parameter  int DATA_W    = 8,
    parameter  int NUM_IN    = 16,
    parameter  int OUT_LANES = 4,
    localparam int NUM_BEATS = NUM_IN / OUT_LANES,
    localparam int BW        = $clog2(NUM_BEATS) + 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [NUM_IN*DATA_W-1:0]    in_data,
    input  logic [BW-1:0]               in_beats,
    input  logic                        in_reverse,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [OUT_LANES*DATA_W-1:0] out_data,
    output logic [BW-1:0]               out_beat_idx,
    output logic                        out_last,
    output logic                        busy
);

    localparam int            GW = OUT_LANES * DATA_W;
    localparam logic [BW-1:0] NB = BW'(NUM_BEATS);

    typedef enum logic {IDLE, SEND} state_t;

    state_t                    state_q, state_d;
    logic [NUM_IN*DATA_W-1:0]  buf_q, buf_d;
    logic [BW-1:0]             n_q, n_d;
    logic [BW-1:0]             cnt_q, cnt_d;
    logic                      rev_q, rev_d;

    logic [BW-1:0]             beats_clamped;
    logic [BW-1:0]             grp;
    logic                      last_beat;
    logic                      xfer;
    logic                      accept;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            buf_q   <= '0;
            n_q     <= '0;
            cnt_q   <= '0;
            rev_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
            rev_q   <= rev_d;
        end
    end

    always_comb begin
        beats_clamped = in_beats;
        if (in_beats == '0 || in_beats > NB)
            beats_clamped = NB;
    end

    // Outputs are decoded from registered state only, so an asynchronous
    // reset clears them without waiting for a clock edge.
    always_comb begin
        out_valid    = (state_q == SEND);
        busy         = (state_q == SEND);
        last_beat    = (state_q == SEND) && (cnt_q == n_q - BW'(1));
        out_last     = last_beat;
        xfer         = out_valid && out_ready;
        // Accepting on the final transfer lets the next packet follow with no bubble.
        in_ready     = (state_q == IDLE) || (xfer && last_beat);
        accept       = in_valid && in_ready;
        grp          = rev_q ? (n_q - BW'(1) - cnt_q) : cnt_q;
        out_beat_idx = out_valid ? grp : '0;
        out_data     = '0;
        if (out_valid) begin
            for (int unsigned b = 0; b < unsigned'(NUM_BEATS); b++) begin
                if (grp == BW'(b))
                    out_data = buf_q[b*GW +: GW];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        n_d     = n_q;
        cnt_d   = cnt_q;
        rev_d   = rev_q;
        if (accept) begin
            state_d = SEND;
            buf_d   = in_data;
            n_d     = beats_clamped;
            rev_d   = in_reverse;
            cnt_d   = '0;
        end else if (xfer) begin
            if (last_beat) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + BW'(1);
            end
        end
    end

endmodule

// File: tb/tb_lane_group_serializer.sv
// Scoreboard bench for lane_group_serializer (default parameters: 16 lanes
// of 8 bits in, 4-lane beats out). Stimulus pushes hand-computed beats into
// a queue; an independent negedge monitor pops and compares each transfer.
module tb_lane_group_serializer;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [2:0]   in_beats;
    logic         in_reverse;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_data;
    logic [2:0]   out_beat_idx;
    logic         out_last;
    logic         busy;

    lane_group_serializer #(.DATA_W(8), .NUM_IN(16), .OUT_LANES(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_beats     (in_beats),
        .in_reverse   (in_reverse),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_beat_idx (out_beat_idx),
        .out_last     (out_last),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic [2:0]  idx;
        logic        last;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passes = 0;
    logic acc_last;

    localparam logic [127:0] INC_DATA = 128'h100F0E0D_0C0B0A09_08070605_04030201;
    localparam logic [127:0] A_DATA   = 128'hAFAEADAC_ABAAA9A8_A7A6A5A4_A3A2A1A0;
    logic [31:0] inc_w [4] = '{32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h100F0E0D};
    logic [31:0] a_w   [4] = '{32'hA3A2A1A0, 32'hA7A6A5A4, 32'hABAAA9A8, 32'hAFAEADAC};

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    task automatic push_beat(input logic [31:0] d, input int idx, input logic last);
        exp_t e;
        e.d = d; e.idx = 3'(idx); e.last = last;
        exp_q.push_back(e);
    endtask

    // Expected beat order: group k forward, N-1-k reversed.
    task automatic push_seq(input logic [31:0] w [4], input int n, input logic rev);
        for (int k = 0; k < n; k++) begin
            int g;
            g = rev ? (n - 1 - k) : k;
            push_beat(w[g], g, k == n - 1);
        end
    endtask

    // Called at posedge+1; returns at (accept edge)+1 with in_valid dropped
    // and in_data scrambled.
    task automatic issue(input logic [127:0] d, input logic [2:0] nb, input logic rv);
        bit ok;
        ok = 0;
        in_data = d; in_beats = nb; in_reverse = rv; in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                acc_last = out_last;
                break;
            end
        end
        checks++;
        if (ok) passes++;
        else $display("FAIL accept_timeout: got no in_ready expected in_ready within 100 cycles");
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = '1;
    endtask

    task automatic wait_idle(input string nm);
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (!busy) break;
        end
        chk({nm, "_idle"}, 64'(busy), 64'd0);
        chk({nm, "_drain"}, 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor: compare every transferred beat; idle output must read 0.
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_beat: got data 0x%0h idx %0d expected no beat", out_data, out_beat_idx);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("beat_data", 64'(out_data), 64'(e.d));
                chk("beat_idx",  64'(out_beat_idx), 64'(e.idx));
                chk("beat_last", 64'(out_last), 64'(e.last));
            end
        end else if (!out_valid) begin
            chk("idle_data_zero", 64'(out_data), 64'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before 200000");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = '0; in_beats = '0;
        in_reverse = 1'b0; out_ready = 1'b1; acc_last = 1'b0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy",      64'(busy), 64'd0);
        chk("rst_out_data",  64'(out_data), 64'd0);
        chk("rst_out_last",  64'(out_last), 64'd0);
        chk("rst_idx",       64'(out_beat_idx), 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Forward, 4 beats, with cycle-accurate latency checks
        push_seq(inc_w, 4, 1'b0);
        issue(INC_DATA, 3'd4, 1'b0);
        chk("fwd_first_valid", 64'(out_valid), 64'd1);
        chk("fwd_busy",        64'(busy), 64'd1);
        chk("fwd_in_ready_0",  64'(in_ready), 64'd0);
        chk("fwd_first_data",  64'(out_data), 64'h04030201);
        repeat (3) @(posedge clk);
        #1;
        chk("fwd_last_flag",   64'(out_last), 64'd1);
        chk("fwd_last_data",   64'(out_data), 64'h100F0E0D);
        chk("fwd_last_in_rdy", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        chk("fwd_done_busy",   64'(busy), 64'd0);
        chk("fwd_done_valid",  64'(out_valid), 64'd0);
        wait_idle("fwd");

        // Reverse, 4 beats
        push_seq(inc_w, 4, 1'b1);
        issue(INC_DATA, 3'd4, 1'b1);
        chk("rev_first_idx", 64'(out_beat_idx), 64'd3);
        wait_idle("rev");

        // Beat counts 2 fwd / 2 rev, 0 and 7 clamp to 4
        push_seq(inc_w, 2, 1'b0);
        issue(INC_DATA, 3'd2, 1'b0);
        wait_idle("n2_fwd");
        push_seq(inc_w, 2, 1'b1);
        issue(INC_DATA, 3'd2, 1'b1);
        wait_idle("n2_rev");
        push_seq(inc_w, 4, 1'b0);
        issue(INC_DATA, 3'd0, 1'b0);
        wait_idle("n0");
        push_seq(inc_w, 4, 1'b0);
        issue(INC_DATA, 3'd7, 1'b0);
        wait_idle("n7");

        // Backpressure on beat 1
        push_seq(inc_w, 4, 1'b0);
        issue(INC_DATA, 3'd4, 1'b0);
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("bp_data",     64'(out_data), 64'h08070605);
            chk("bp_idx",      64'(out_beat_idx), 64'd1);
            chk("bp_last",     64'(out_last), 64'd0);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_valid",    64'(out_valid), 64'd1);
        end
        out_ready = 1'b1;
        wait_idle("bp");

        // Back-to-back: second packet held valid while first streams
        push_seq(inc_w, 4, 1'b0);
        issue(INC_DATA, 3'd4, 1'b0);
        push_seq(a_w, 4, 1'b0);
        issue(A_DATA, 3'd4, 1'b0);
        chk("b2b_accept_on_last", 64'(acc_last), 64'd1);
        chk("b2b_no_bubble",      64'(out_valid), 64'd1);
        chk("b2b_first_data",     64'(out_data), 64'hA3A2A1A0);
        chk("b2b_first_idx",      64'(out_beat_idx), 64'd0);
        wait_idle("b2b");

        // Asynchronous reset during beat 2
        push_seq(inc_w, 4, 1'b0);
        issue(INC_DATA, 3'd4, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_rst_beat2_idx", 64'(out_beat_idx), 64'd2);
        #1 reset = 1'b1;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_busy",      64'(busy), 64'd0);
        chk("arst_out_data",  64'(out_data), 64'd0);
        chk("arst_beats_done", 64'(exp_q.size()), 64'd2);
        exp_q.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        chk("arst_in_ready", 64'(in_ready), 64'd1);
        push_seq(inc_w, 4, 1'b1);
        issue(INC_DATA, 3'd4, 1'b1);
        chk("arst_restart_idx", 64'(out_beat_idx), 64'd3);
        wait_idle("arst");

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
